// File: rtl/controlador_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_mem_if
// Description : Command/completion bundle between the MESI state machine
//               (master) and the memory controller (slave).
//               master drives : cmd_valid, cmd, bloco
//               slave drives  : cmd_ready, done, done_cmd, done_bloco,
//                               ocupado, cnt_leitura, cnt_escrita, erro
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_mem_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] bloco;
    logic       cmd_ready;
    logic       done;
    logic [1:0] done_cmd;
    logic [3:0] done_bloco;
    logic       ocupado;
    logic [7:0] cnt_leitura;
    logic [7:0] cnt_escrita;
    logic       erro;

    modport master (
        output cmd_valid, cmd, bloco,
        input  cmd_ready, done, done_cmd, done_bloco, ocupado,
               cnt_leitura, cnt_escrita, erro
    );

    modport slave (
        input  cmd_valid, cmd, bloco,
        output cmd_ready, done, done_cmd, done_bloco, ocupado,
               cnt_leitura, cnt_escrita, erro
    );
endinterface
`default_nettype wire

// File: rtl/controlador_mem.sv
`default_nettype none
// ============================================================================
// Module      : controlador_mem
// Description : Memory controller behind a MESI cache. Legal commands
//               (LEITURA/ESCRITA) are queued in a PROF-deep FIFO and serviced
//               one at a time, each taking LATENCIA cycles, followed by a
//               one-cycle completion pulse. Keeps saturating completion
//               counters and a sticky illegal-command flag.
// Ports       : clock  - single clock, rising edge
//               resetn - asynchronous active-low reset
//               bus    - controlador_mem_if.slave (command in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_mem #(
    parameter int LATENCIA = 3,   // service cycles per command, 1..15
    parameter int PROF     = 4    // FIFO depth, power of two, 2..16
) (
    input  wire logic          clock,
    input  wire logic          resetn,
    controlador_mem_if.slave   bus
);

    localparam int             AW         = $clog2(PROF);
    localparam logic [3:0]     LAT_CARGA  = 4'(LATENCIA - 1);
    localparam logic [AW:0]    OCUP_CHEIO = (AW + 1)'(PROF);
    localparam logic [AW:0]    OCUP_UM    = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_UM     = AW'(1);
    localparam logic [1:0]     CMD_LEITURA = 2'b01;
    localparam logic [1:0]     CMD_ESCRITA = 2'b10;
    localparam logic [1:0]     CMD_ILEGAL  = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t        estado_q,     estado_d;
    logic [AW-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [AW:0]    ocup_q,       ocup_d;
    logic [3:0]     lat_q,        lat_d;
    logic [5:0]     trab_q,       trab_d;      // {cmd, bloco} in service
    logic [5:0]     mem_q [PROF];
    logic [5:0]     mem_d [PROF];
    logic           done_q,       done_d;
    logic [1:0]     done_cmd_q,   done_cmd_d;
    logic [3:0]     done_bloco_q, done_bloco_d;
    logic [7:0]     cnt_leit_q,   cnt_leit_d;
    logic [7:0]     cnt_escr_q,   cnt_escr_d;
    logic           erro_q,       erro_d;

    logic           cmd_ready;
    logic           cmd_legal;
    logic           push;
    logic           pop;

    // Readiness looks only at registered occupancy, so a pop on the same
    // edge never lets a full FIFO take a new command.
    assign cmd_ready = (ocup_q != OCUP_CHEIO);
    assign cmd_legal = (bus.cmd == CMD_LEITURA) || (bus.cmd == CMD_ESCRITA);
    assign push      = bus.cmd_valid && cmd_ready && cmd_legal;
    assign pop       = (estado_q == OCIOSO) && (ocup_q != '0);

    // ---------------- FIFO storage and pointers ----------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ocup_d   = ocup_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd, bus.bloco};
            wr_ptr_d        = wr_ptr_q + PTR_UM;   // wraps modulo PROF
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_UM;
        end
        if (push && !pop) begin
            ocup_d = ocup_q + OCUP_UM;
        end else if (pop && !push) begin
            ocup_d = ocup_q - OCUP_UM;
        end
    end

    // ---------------- error flag ----------------
    always_comb begin
        erro_d = erro_q;
        if (bus.cmd_valid && (bus.cmd == CMD_ILEGAL)) begin
            erro_d = 1'b1;
        end
    end

    // ---------------- service FSM ----------------
    always_comb begin
        estado_d     = estado_q;
        lat_d        = lat_q;
        trab_d       = trab_q;
        done_d       = 1'b0;
        done_cmd_d   = done_cmd_q;
        done_bloco_d = done_bloco_q;
        cnt_leit_d   = cnt_leit_q;
        cnt_escr_d   = cnt_escr_q;
        unique case (estado_q)
            OCIOSO: begin
                if (pop) begin
                    trab_d   = mem_q[rd_ptr_q];
                    lat_d    = LAT_CARGA;
                    estado_d = ESPERA;
                end
            end
            ESPERA: begin
                if (lat_q == 4'd0) begin
                    // Completion is registered on the edge entering CONCLUI.
                    estado_d     = CONCLUI;
                    done_d       = 1'b1;
                    done_cmd_d   = trab_q[5:4];
                    done_bloco_d = trab_q[3:0];
                    if ((trab_q[5:4] == CMD_LEITURA) && (cnt_leit_q != 8'hFF)) begin
                        cnt_leit_d = cnt_leit_q + 8'd1;
                    end
                    if ((trab_q[5:4] == CMD_ESCRITA) && (cnt_escr_q != 8'hFF)) begin
                        cnt_escr_d = cnt_escr_q + 8'd1;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            CONCLUI: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado_q     <= OCIOSO;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ocup_q       <= '0;
            lat_q        <= '0;
            trab_q       <= '0;
            for (int i = 0; i < PROF; i++) begin
                mem_q[i] <= '0;
            end
            done_q       <= 1'b0;
            done_cmd_q   <= '0;
            done_bloco_q <= '0;
            cnt_leit_q   <= '0;
            cnt_escr_q   <= '0;
            erro_q       <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ocup_q       <= ocup_d;
            lat_q        <= lat_d;
            trab_q       <= trab_d;
            mem_q        <= mem_d;
            done_q       <= done_d;
            done_cmd_q   <= done_cmd_d;
            done_bloco_q <= done_bloco_d;
            cnt_leit_q   <= cnt_leit_d;
            cnt_escr_q   <= cnt_escr_d;
            erro_q       <= erro_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.done        = done_q;
    assign bus.done_cmd    = done_cmd_q;
    assign bus.done_bloco  = done_bloco_q;
    assign bus.ocupado     = (estado_q != OCIOSO) || (ocup_q != '0);
    assign bus.cnt_leitura = cnt_leit_q;
    assign bus.cnt_escrita = cnt_escr_q;
    assign bus.erro        = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_mem
// Description : Self-checking bench for controlador_mem. A timestamp-based
//               model (queue of pending commands plus the edge at which the
//               current command was popped) predicts every output after
//               every clock edge; directed sequences pin the model with
//               literal expectations, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_mem;

    localparam int L = 3;
    localparam int P = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    controlador_mem_if bus();

    controlador_mem #(.LATENCIA(L), .PROF(P)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [5:0] mq[$];      // accepted, not yet popped
    int         edge_n = 0; // edges counted since start
    bit         has_svc = 0;
    int         ep = 0;     // edge at which current command was popped
    logic [5:0] cur = '0;
    bit         m_done = 0;
    logic [1:0] m_dcmd = '0;
    logic [3:0] m_dblk = '0;
    int         m_cl = 0, m_ce = 0;
    bit         m_erro = 0;

    // observation helpers
    int         done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ocupado();
        return (has_svc && edge_n >= ep && edge_n <= ep + L) || (mq.size() > 0);
    endfunction

    // Effect of one rising edge with the given inputs.
    task automatic model_edge(input logic v, input logic [1:0] c, input logic [3:0] b);
        int sz;
        bit rdy, idle;
        edge_n++;
        sz   = mq.size();
        rdy  = (sz != P);
        // controller is idle before this edge unless within (ep, ep+L+1]
        idle = !(has_svc && edge_n >= ep + 1 && edge_n <= ep + L + 1);
        m_done = 0;
        if (has_svc && edge_n == ep + L) begin
            m_done = 1;
            m_dcmd = cur[5:4];
            m_dblk = cur[3:0];
            if (cur[5:4] == 2'b01 && m_cl < 255) m_cl++;
            if (cur[5:4] == 2'b10 && m_ce < 255) m_ce++;
        end
        if (idle && sz > 0) begin
            cur     = mq.pop_front();
            ep      = edge_n;
            has_svc = 1;
        end
        if (v && rdy && (c == 2'b01 || c == 2'b10)) mq.push_back({c, b});
        if (v && c == 2'b11) m_erro = 1;
    endtask

    task automatic model_reset();
        mq.delete();
        has_svc = 0;
        m_done  = 0;
        m_dcmd  = '0;
        m_dblk  = '0;
        m_cl    = 0;
        m_ce    = 0;
        m_erro  = 0;
    endtask

    task automatic compare_all();
        chk("cmd_ready",   bus.cmd_ready,   (mq.size() != P));
        chk("done",        bus.done,        m_done);
        chk("ocupado",     bus.ocupado,     m_ocupado());
        chk("cnt_leitura", bus.cnt_leitura, m_cl);
        chk("cnt_escrita", bus.cnt_escrita, m_ce);
        chk("erro",        bus.erro,        m_erro);
        if (m_done) begin
            chk("done_cmd",   bus.done_cmd,   m_dcmd);
            chk("done_bloco", bus.done_bloco, m_dblk);
        end
        if (bus.done === 1'b1) done_cnt++;
    endtask

    // Called just after an edge (+1); drives inputs for the next edge.
    task automatic step(input logic v, input logic [1:0] c, input logic [3:0] b);
        bus.cmd_valid = v;
        bus.cmd       = c;
        bus.bloco     = b;
        model_edge(v, c, b);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0);
    endtask

    // Mid-cycle asynchronous reset held across one edge with a push offered.
    task automatic do_reset();
        bus.cmd_valid = 1'b1;
        bus.cmd       = 2'b01;
        bus.bloco     = 4'hF;
        resetn        = 1'b0;
        #1;
        model_reset();
        chk("rst_cmd_ready",  bus.cmd_ready,   1);
        chk("rst_ocupado",    bus.ocupado,     0);
        chk("rst_done",       bus.done,        0);
        chk("rst_done_cmd",   bus.done_cmd,    0);
        chk("rst_done_bloco", bus.done_bloco,  0);
        chk("rst_cnt_l",      bus.cnt_leitura, 0);
        chk("rst_cnt_e",      bus.cnt_escrita, 0);
        chk("rst_erro",       bus.erro,        0);
        @(posedge clock);
        #1;
        chk("rst_hold_ocupado", bus.ocupado, 0);
        resetn        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.bloco     = 4'h0;
    endtask

    initial begin : main
        int done_edge;
        logic [1:0] cap_cmd;
        logic [3:0] cap_blk;
        int r;
        logic [1:0] rc;

        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        bus.bloco     = 4'h0;
        @(posedge clock);
        #1;

        // ---- single LEITURA: done exactly at relative edge 4 ----
        do_reset();
        done_cnt  = 0;
        done_edge = -1;
        cap_cmd   = '0;
        cap_blk   = '0;
        step(1'b1, 2'b01, 4'b0101);   // edge 0
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 2'b00, 4'h0);
            if (bus.done === 1'b1 && done_edge < 0) begin
                done_edge = k;
                cap_cmd   = bus.done_cmd;
                cap_blk   = bus.done_bloco;
            end
        end
        chk("lit_done_edge",  done_edge,       4);
        chk("lit_done_count", done_cnt,        1);
        chk("lit_done_cmd",   cap_cmd,         1);
        chk("lit_done_bloco", cap_blk,         5);
        chk("lit_cnt_l",      bus.cnt_leitura, 1);

        // ---- burst of 7 pushes against a 4-deep FIFO ----
        do_reset();
        done_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            step(1'b1, (k % 2 == 1) ? 2'b10 : 2'b01, 4'(k + 1));
            if (k == 4) chk("lit_full_ready", bus.cmd_ready, 0);
            if (k == 5) chk("lit_full_ready2", bus.cmd_ready, 0);
            if (k == 6) chk("lit_pop_ready", bus.cmd_ready, 1);
        end
        idle(40);
        chk("lit_burst_dones", done_cnt, 5);
        chk("lit_burst_ocup",  bus.ocupado, 0);

        // ---- illegal then NOP ----
        do_reset();
        done_cnt = 0;
        step(1'b1, 2'b11, 4'h3);
        step(1'b1, 2'b00, 4'h4);
        chk("lit_erro_set",  bus.erro,    1);
        chk("lit_erro_ocup", bus.ocupado, 0);
        idle(10);
        chk("lit_erro_sticky", bus.erro, 1);
        chk("lit_erro_nodone", done_cnt, 0);

        // ---- ESCRITA counter saturation ----
        do_reset();
        step(1'b1, 2'b01, 4'h1);
        idle(L + 1);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 2'b10, 4'(i));
            idle(L + 1);
        end
        idle(5);
        chk("lit_sat_escrita", bus.cnt_escrita, 255);
        chk("lit_sat_leitura", bus.cnt_leitura, 1);

        // ---- reset during ESPERA with two queued ----
        do_reset();
        step(1'b1, 2'b01, 4'hA);
        step(1'b1, 2'b10, 4'hB);
        step(1'b1, 2'b01, 4'hC);
        do_reset();
        done_cnt = 0;
        idle(10);
        chk("lit_abandon_nodone", done_cnt, 0);
        step(1'b1, 2'b10, 4'h7);
        idle(8);
        chk("lit_after_rst_done", done_cnt,        1);
        chk("lit_after_rst_cnt",  bus.cnt_escrita, 1);

        // ---- randomized traffic with occasional resets ----
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 15);
                if (r == 0)      rc = 2'b11;
                else if (r < 3)  rc = 2'b00;
                else if (r < 9)  rc = 2'b01;
                else             rc = 2'b10;
                // bursty: stretches of heavy and light offering
                step(((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 7) == 0),
                     rc, 4'($urandom));
            end
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
